// File: rtl/traffic_pkg.sv
// traffic_pkg: shared types and helpers for the two-road intersection controller.
//   phase_e       : six-phase light sequence plus the night FLASH state
//   LIGHT_*       : {red, yellow, green} lamp codes
//   CNT_W         : width of the per-phase countdown
//   next_phase()  : cyclic phase order
//   phase_lights(): {a_lights, b_lights} for a phase (flash bit used only in FLASH)
package traffic_pkg;

   localparam int unsigned CNT_W = 7;

   localparam logic [2:0] LIGHT_RED    = 3'b100;
   localparam logic [2:0] LIGHT_YELLOW = 3'b010;
   localparam logic [2:0] LIGHT_GREEN  = 3'b001;

   typedef enum logic [2:0] {
      A_GREEN  = 3'd0,
      A_YELLOW = 3'd1,
      ALLRED_1 = 3'd2,
      B_GREEN  = 3'd3,
      B_YELLOW = 3'd4,
      ALLRED_2 = 3'd5,
      FLASH    = 3'd6
   } phase_e;

   // Cyclic successor; FLASH is left through its own path, never by countdown.
   function automatic phase_e next_phase(input phase_e p);
      case (p)
         A_GREEN:  return A_YELLOW;
         A_YELLOW: return ALLRED_1;
         ALLRED_1: return B_GREEN;
         B_GREEN:  return B_YELLOW;
         B_YELLOW: return ALLRED_2;
         default:  return A_GREEN;
      endcase
   endfunction

   // Lamp pattern {a, b} for a phase.
   function automatic logic [5:0] phase_lights(input phase_e p, input logic flash);
      case (p)
         A_GREEN:  return {LIGHT_GREEN,  LIGHT_RED};
         A_YELLOW: return {LIGHT_YELLOW, LIGHT_RED};
         B_GREEN:  return {LIGHT_RED,    LIGHT_GREEN};
         B_YELLOW: return {LIGHT_RED,    LIGHT_YELLOW};
         FLASH:    return {1'b0, flash, 1'b0, 1'b0, flash, 1'b0};
         default:  return {LIGHT_RED,    LIGHT_RED};
      endcase
   endfunction

endpackage

// File: rtl/traffic_if.sv
// traffic_if: board-side signals of the intersection controller.
//   ped_req, night         : button / switch inputs to the controller
//   a_lights, b_lights     : {red, yellow, green} per road
//   walk                   : pedestrian lamp
//   sec_tens, sec_ones     : BCD countdown digits for the 7-segment decoders
//   tick                   : one-cycle tick pulse
//   master = controller side, slave = board / observer side
interface traffic_if;
   logic       ped_req;
   logic       night;
   logic [2:0] a_lights;
   logic [2:0] b_lights;
   logic       walk;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       tick;

   modport master (
      input  ped_req, night,
      output a_lights, b_lights, walk, sec_tens, sec_ones, tick
   );

   modport slave (
      output ped_req, night,
      input  a_lights, b_lights, walk, sec_tens, sec_ones, tick
   );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: divides clk by DIV = CLK_HZ/TICK_HZ into a one-cycle tick.
//   clk  in  : system clock
//   rst  in  : asynchronous active-high reset
//   tick out : high for the one cycle in which the divider sits at DIV-1
module tick_gen #(
   parameter int unsigned CLK_HZ  = 50_000_000,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic clk,
   input  logic rst,
   output logic tick
);

   localparam int unsigned DIV = CLK_HZ / TICK_HZ;
   localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] cnt;

   // tick is registered one step early so it coincides with cnt == DIV-1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         tick <= 1'b0;
      end else begin
         tick <= (cnt == W'(DIV - 2));
         cnt  <= (cnt == W'(DIV - 1)) ? '0 : cnt + W'(1);
      end
   end

endmodule

// File: rtl/traffic_ctrl.sv
// traffic_ctrl: two-road intersection controller (main road A, side road B).
//   CLOCK_50 in : system clock
//   reset    in : asynchronous active-high reset
//   bus          : traffic_if.master (ped_req, night in; lights, walk, digits, tick out)
// Optional: define NIGHT_FLASH_EN to build the night FLASH mode; otherwise night is ignored.
module traffic_ctrl
   import traffic_pkg::*;
#(
   parameter int unsigned CLK_HZ      = 50_000_000,
   parameter int unsigned TICK_HZ     = 1,
   parameter int unsigned A_GREEN_S   = 10,
   parameter int unsigned YELLOW_S    = 4,
   parameter int unsigned ALLRED_S    = 1,
   parameter int unsigned B_GREEN_S   = 6,
   parameter int unsigned MIN_GREEN_S = 3
) (
   input  logic       CLOCK_50,
   input  logic       reset,
   traffic_if.master  bus
);

   logic             tick;
   logic             ped_s1, ped_s2, ped_s3;
   logic             ped_rise;
   logic             pend_q, pend_d;
   phase_e           phase_q, phase_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             walk_q, walk_d;
   logic             flash_q, flash_d;
   logic [5:0]       lights_q, lights_d;

   // Reload value (duration - 1) for a phase.
   function automatic logic [CNT_W-1:0] dur_m1(input phase_e p);
      case (p)
         A_GREEN:            return CNT_W'(A_GREEN_S - 1);
         A_YELLOW, B_YELLOW: return CNT_W'(YELLOW_S - 1);
         ALLRED_1, ALLRED_2: return CNT_W'(ALLRED_S - 1);
         B_GREEN:            return CNT_W'(B_GREEN_S - 1);
         default:            return '0;
      endcase
   endfunction

   tick_gen #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) u_tick_gen (
      .clk  (CLOCK_50),
      .rst  (reset),
      .tick (tick)
   );

   assign ped_rise = ped_s2 & ~ped_s3;

   // State register: phase, countdown, walk, flash, lamps, pedestrian latch.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         ped_s1   <= 1'b0;
         ped_s2   <= 1'b0;
         ped_s3   <= 1'b0;
         pend_q   <= 1'b0;
         phase_q  <= A_GREEN;
         count_q  <= CNT_W'(A_GREEN_S - 1);
         walk_q   <= 1'b0;
         flash_q  <= 1'b0;
         lights_q <= {LIGHT_GREEN, LIGHT_RED};
      end else begin
         ped_s1   <= bus.ped_req;
         ped_s2   <= ped_s1;
         ped_s3   <= ped_s2;
         pend_q   <= pend_d;
         phase_q  <= phase_d;
         count_q  <= count_d;
         walk_q   <= walk_d;
         flash_q  <= flash_d;
         lights_q <= lights_d;
      end
   end

   // Next-state logic; everything moves only on tick except the request latch.
   always_comb begin
      phase_d = phase_q;
      count_d = count_q;
      walk_d  = walk_q;
      flash_d = flash_q;
      pend_d  = pend_q | ped_rise;

      if (tick) begin
`ifdef NIGHT_FLASH_EN
         if (bus.night) begin
            phase_d = FLASH;
            count_d = '0;
            walk_d  = 1'b0;
            flash_d = (phase_q == FLASH) ? ~flash_q : 1'b1;
         end else if (phase_q == FLASH) begin
            phase_d = ALLRED_1;
            count_d = dur_m1(ALLRED_1);
         end else
`endif
         if (count_q == '0) begin
            phase_d = next_phase(phase_q);
            count_d = dur_m1(phase_d);
            if (phase_d == B_GREEN) begin
               // Grant consumes the pending request; a press landing this very cycle stays latched.
               walk_d = pend_q;
               pend_d = ped_rise;
            end else begin
               walk_d = 1'b0;
            end
         end else if (phase_q == A_GREEN && pend_q && count_q > CNT_W'(MIN_GREEN_S - 1)) begin
            count_d = CNT_W'(MIN_GREEN_S - 1);
         end else begin
            count_d = count_q - CNT_W'(1);
         end
      end

`ifdef NIGHT_FLASH_EN
      if (phase_d == FLASH) pend_d = 1'b0;
`endif

      lights_d = phase_lights(phase_d, flash_d);
   end

`ifndef NIGHT_FLASH_EN
   logic unused_night;
   assign unused_night = bus.night;
`endif

   assign bus.a_lights = lights_q[5:3];
   assign bus.b_lights = lights_q[2:0];
   assign bus.walk     = walk_q;
   assign bus.tick     = tick;
   assign bus.sec_tens = 4'(count_q / CNT_W'(10));
   assign bus.sec_ones = 4'(count_q % CNT_W'(10));

endmodule

// File: tb/tb_traffic_ctrl.sv
// tb_traffic_ctrl: scoreboard bench for traffic_ctrl at CLK_HZ=10, TICK_HZ=1 (DIV=10).
// Stimulus pushes the expected post-tick lamp/digit state; the monitor pops one entry per tick.
module tb_traffic_ctrl;

   localparam logic [2:0] R = 3'b100;
   localparam logic [2:0] Y = 3'b010;
   localparam logic [2:0] G = 3'b001;
   localparam logic [2:0] O = 3'b000;

   typedef struct packed {
      logic [2:0] a;
      logic [2:0] b;
      logic       walk;
      logic [3:0] tens;
      logic [3:0] ones;
   } obs_t;

   logic CLOCK_50 = 1'b0;
   logic reset;

   traffic_if bus ();

   traffic_ctrl #(
      .CLK_HZ  (10),
      .TICK_HZ (1)
   ) dut (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .bus      (bus)
   );

   always #5 CLOCK_50 = ~CLOCK_50;

   obs_t exp_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   tick_no  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic obs_t mk(input logic [2:0] a, input logic [2:0] b, input logic w, input int c);
      obs_t o;
      o.a    = a;
      o.b    = b;
      o.walk = w;
      o.tens = 4'(c / 10);
      o.ones = 4'(c % 10);
      return o;
   endfunction

   // Push one phase's countdown, from_c down to to_c inclusive.
   task automatic push_run(input logic [2:0] a, input logic [2:0] b, input logic w,
                           input int from_c, input int to_c);
      for (int c = from_c; c >= to_c; c--) exp_q.push_back(mk(a, b, w, c));
   endtask

   function automatic obs_t sample_obs();
      return {bus.a_lights, bus.b_lights, bus.walk, bus.sec_tens, bus.sec_ones};
   endfunction

   task automatic wait_drain(input string name);
      for (int i = 0; i < 2000 && exp_q.size() != 0; i++) @(negedge CLOCK_50);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: got %0d entries left, expected 0", name, exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic pulse_ped();
      bus.ped_req = 1'b1;
      repeat (3) @(negedge CLOCK_50);
      bus.ped_req = 1'b0;
   endtask

   // Monitor: the state visible one cycle after each tick is compared to the scoreboard head.
   initial begin
      obs_t e;
      forever begin
         @(negedge CLOCK_50);
         if (reset === 1'b0 && bus.tick === 1'b1) begin
            @(negedge CLOCK_50);
            tick_no++;
            check($sformatf("tick_width%0d", tick_no), 32'(bus.tick), 32'd0);
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_tick%0d: got %0h, expected no tick", tick_no, sample_obs());
            end else begin
               e = exp_q.pop_front();
               check($sformatf("tick%0d", tick_no), 32'(sample_obs()), 32'(e));
               if (e.a == R || e.b == R)
                  check($sformatf("conflict%0d", tick_no),
                        32'(bus.a_lights != R && bus.b_lights != R), 32'd0);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;
      reset       = 1'b1;
      bus.ped_req = 1'b0;
      bus.night   = 1'b0;
      repeat (3) @(negedge CLOCK_50);

      // Reset state.
      check("rst_a", 32'(bus.a_lights), 32'(G));
      check("rst_b", 32'(bus.b_lights), 32'(R));
      check("rst_walk", 32'(bus.walk), 32'd0);
      check("rst_tick", 32'(bus.tick), 32'd0);
      check("rst_digits", 32'({bus.sec_tens, bus.sec_ones}), 32'h09);

      // Free run: first A_GREEN 9 -> 0, then a full 26-tick cycle, then A_GREEN restarts.
      push_run(G, R, 1'b0, 8, 0);
      push_run(Y, R, 1'b0, 3, 0);
      push_run(R, R, 1'b0, 0, 0);
      push_run(R, G, 1'b0, 5, 0);
      push_run(R, Y, 1'b0, 3, 0);
      push_run(R, R, 1'b0, 0, 0);
      push_run(G, R, 1'b0, 9, 8);
      reset = 1'b0;

      n = 1;
      while (bus.tick !== 1'b1 && n < 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("first_tick_cycle", 32'(n), 32'd10);
      @(negedge CLOCK_50);
      n = 1;
      while (bus.tick !== 1'b1 && n < 100) begin
         @(negedge CLOCK_50);
         n++;
      end
      check("tick_period", 32'(n), 32'd10);
      wait_drain("drain_free_run");

      // Pedestrian press at A_GREEN count 8: cut to 2, walk through B_GREEN.
      push_run(G, R, 1'b0, 2, 0);
      push_run(Y, R, 1'b0, 3, 0);
      push_run(R, R, 1'b0, 0, 0);
      push_run(R, G, 1'b1, 5, 0);
      push_run(R, Y, 1'b0, 3, 3);
      pulse_ped();
      wait_drain("drain_ped_a_green");

      // Press during B_YELLOW: held until A_GREEN, whose first tick cuts 9 to 2.
      push_run(R, Y, 1'b0, 2, 0);
      push_run(R, R, 1'b0, 0, 0);
      push_run(G, R, 1'b0, 9, 9);
      push_run(G, R, 1'b0, 2, 0);
      push_run(Y, R, 1'b0, 3, 0);
      push_run(R, R, 1'b0, 0, 0);
      push_run(R, G, 1'b1, 5, 2);
      pulse_ped();
      wait_drain("drain_ped_b_yellow");

      // Reset in mid B_GREEN with walk lit.
      repeat (3) @(negedge CLOCK_50);
      check("pre_rst_walk", 32'(bus.walk), 32'd1);
      reset = 1'b1;
      #1;
      check("mid_rst_a", 32'(bus.a_lights), 32'(G));
      check("mid_rst_b", 32'(bus.b_lights), 32'(R));
      check("mid_rst_walk", 32'(bus.walk), 32'd0);
      check("mid_rst_tick", 32'(bus.tick), 32'd0);
      check("mid_rst_digits", 32'({bus.sec_tens, bus.sec_ones}), 32'h09);
      repeat (2) @(negedge CLOCK_50);
      push_run(G, R, 1'b0, 8, 7);
      reset = 1'b0;
      wait_drain("drain_after_reset");

`ifdef NIGHT_FLASH_EN
      // Night flash from A_GREEN, then back through ALLRED_1 into B_GREEN.
      bus.night = 1'b1;
      exp_q.push_back(mk(Y, Y, 1'b0, 0));
      exp_q.push_back(mk(O, O, 1'b0, 0));
      exp_q.push_back(mk(Y, Y, 1'b0, 0));
      wait_drain("drain_flash");
      bus.night = 1'b0;
      push_run(R, R, 1'b0, 0, 0);
      push_run(R, G, 1'b0, 5, 4);
      wait_drain("drain_flash_exit");
`else
      // night has no effect in this build.
      bus.night = 1'b1;
      push_run(G, R, 1'b0, 6, 4);
      wait_drain("drain_night_ignored");
      bus.night = 1'b0;
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/traffic_ctrl.md
# traffic_ctrl

- Parametrised two-road intersection controller: main road A, side road B.
- Runs a six-phase light sequence from a one-cycle tick enable, not a derived clock. Phase durations, tick rate and clock rate are parameters.
- Supports a latched pedestrian request that shortens A green and grants a walk phase.
- Drives the board LEDs directly. Two BCD countdown digits feed the existing 7-segment decoders.

## Interface
Parameters:
- CLK_HZ, 50_000_000: input clock frequency.
- TICK_HZ, 1: countdown rate; CLK_HZ/TICK_HZ must be an integer ≥ 2.
- A_GREEN_S, 10: A green duration in ticks, range 1..99.
- YELLOW_S, 4: yellow duration for both roads, range 1..99.
- ALLRED_S, 1: all-red clearance duration, range 1..99.
- B_GREEN_S, 6: B green duration, range 1..99.
- MIN_GREEN_S, 3: A green remaining after a pedestrian request, range 1..A_GREEN_S.

Ports:
- CLOCK_50  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ped_req  in  1  pedestrian button, asynchronous level; a 2-flop synchroniser is internal.
- night  in  1  night-flash request (see Configuration).
- a_lights  out  3  {red, yellow, green} for road A.
- b_lights  out  3  {red, yellow, green} for road B.
- walk  out  1  pedestrian walk lamp.
- sec_tens  out  4  BCD tens digit of remaining count.
- sec_ones  out  4  BCD ones digit of remaining count.
- tick  out  1  one-cycle tick pulse, for debug and display blanking.

## Operation
- Tick generator: counter of width clog2(CLK_HZ/TICK_HZ) counts 0..DIV-1, where DIV=CLK_HZ/TICK_HZ. tick=1 on the cycle the counter equals DIV-1; the counter then wraps to 0.
- Phases, in cyclic order:
  - A_GREEN: a=001, b=100.
  - A_YELLOW: a=010, b=100.
  - ALLRED_1: a=100, b=100.
  - B_GREEN: a=100, b=001.
  - B_YELLOW: a=100, b=010.
  - ALLRED_2: a=100, b=100.
  - After ALLRED_2, back to A_GREEN.
- Countdown: a 7-bit count is loaded with duration−1 on phase entry. Each tick it decrements. A tick with count==0 advances the phase and loads the next duration−1. Each phase therefore lasts exactly duration ticks.
- Pedestrian request:
  - A synchronised rising edge of ped_req sets ped_pending. Further presses while pending are ignored.
  - On a tick in A_GREEN with ped_pending=1 and count > MIN_GREEN_S−1: count loads MIN_GREEN_S−1 instead of decrementing.
  - A request latched in any other phase is held until the next A_GREEN.
  - On entry to B_GREEN: ped_pending clears, and walk=1 for the whole B_GREEN if ped_pending was set; otherwise walk stays 0. walk drops on leaving B_GREEN.
- BCD: sec_tens=count/10 and sec_ones=count%10, derived combinationally from the registered count. Parameters are constrained so count ≤ 98.
- Reset mid-operation:
  - Phase=A_GREEN, count=A_GREEN_S−1, divider=0, ped_pending=0, synchroniser flops=0.
  - Outputs: a=001, b=100, walk=0, tick=0, digits show A_GREEN_S−1.

## Timing
- Phase, count, lights and walk are registered. They update on the CLOCK_50 edge at which tick=1 is sampled, and are visible the cycle after the tick pulse.
- First tick occurs DIV cycles after reset deassertion.
- ped_req to ped_pending latency: 3 cycles (2 synchroniser flops plus edge detect).
- A request that latches in the same cycle as a tick does not affect that tick. It applies from the next tick.
- A request arriving with count ≤ MIN_GREEN_S−1 in A_GREEN does not lengthen the phase.

## Configuration
- NIGHT_FLASH_EN defined:
  - With night=1, the controller enters FLASH at the next tick from any phase. ped_pending is cleared and walk=0.
  - In FLASH, a=b={0, flash, 0}, where flash toggles every tick and starts at 1. The digits show 0.
  - When night returns to 0, the next tick enters ALLRED_1 with count=ALLRED_S−1 and the normal cycle resumes.
- NIGHT_FLASH_EN undefined: the night port exists but is ignored, and the FLASH state is not synthesised.

## Structure
- Package traffic_pkg:
  - Phase state encoding (enum of A_GREEN..ALLRED_2, plus FLASH).
  - Light-code constants LIGHT_RED=3'b100, LIGHT_YELLOW=3'b010, LIGHT_GREEN=3'b001.
- Sub-module tick_gen(CLK_HZ, TICK_HZ): divider producing the one-cycle tick, with asynchronous reset.

## Test plan
All scenarios use CLK_HZ=10, TICK_HZ=1 (DIV=10) with default durations.
- Reset release → tick first at cycle 10; digits count 9→0 over 10 ticks; A_YELLOW entered on the 10th tick with digits=3.
- Free run of one full cycle → phase durations 10/4/1/6/4/1 ticks; a and b never both non-red; the cycle repeats after 26 ticks.
- ped_req pulse at A_GREEN count=8 → next tick loads count=2; A_YELLOW follows 3 ticks later; walk=1 for all 6 B_GREEN ticks, then walk=0.
- ped_req during B_YELLOW → no effect until A_GREEN; its first tick loads count 2; walk is granted in the following B_GREEN.
- reset asserted mid-B_GREEN with walk=1 → same cycle: a=001, b=100, walk=0, digits 09.
- NIGHT_FLASH_EN with night=1 in A_GREEN → next tick: FLASH, yellow toggles each tick; night=0 → next tick: ALLRED_1, then B_GREEN after 1 tick.
